// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the serial ALU sequencer: state encoding, frame
//   length and the width rule for the inter-byte timeout counter.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        GET_OP1    = 3'd0,
        GET_OP2    = 3'd1,
        GET_OPCODE = 3'd2,
        EXEC       = 3'd3,
        WAIT_TX    = 3'd4
    } seq_state_t;

    // Bytes per frame: operand 1, operand 2, opcode.
    localparam int FRAME_LEN = 3;

    localparam int TIMEOUT_CYCLES_DEFAULT = 100_000_000;

    // Counter must hold TIMEOUT_CYCLES-1; never narrower than one bit.
    function automatic int timeout_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    localparam int TIMEOUT_CNT_W = timeout_cnt_width(TIMEOUT_CYCLES_DEFAULT);

endpackage

// File: rtl/frame_timeout_counter.sv
// frame_timeout_counter
//   Idle-cycle counter for serial framing. Counts while i_enable is high,
//   returns to zero on i_clear (which has priority), and flags o_expired
//   combinationally when an enabled cycle finds the count at CYCLES-1.
// Ports:
//   i_clock    system clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_clear    synchronous clear of the count
//   i_enable   count this cycle
//   o_expired  enabled cycle with count at its last value
module frame_timeout_counter
    import alu_seq_pkg::*;
#(
    parameter int CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int CNT_W  = timeout_cnt_width(CYCLES)
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable) begin
            count <= count + 1'b1;
        end
    end

    assign o_expired = i_enable && (count == LAST);

endmodule

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer
//   Loads operand 1, operand 2 and opcode from consecutive uart_rx bytes,
//   gives the external ALU one settle cycle, then captures its result and
//   hands it to uart_tx with a start/done handshake.
// Ports:
//   i_clock, i_reset_n          clock and asynchronous active-low reset
//   i_rx_data, i_rx_valid       received byte and its one-cycle strobe
//   o_op_1, o_op_2, o_opcode    ALU operands/opcode, held between frames
//   i_alu_result                combinational ALU result
//   o_tx_data, o_tx_start       result byte and one-cycle start to uart_tx
//   i_tx_done                   transmission finished strobe
//   o_busy                      high whenever a frame is in progress
//   o_timeout_err               pulse when a frame stalls between bytes
//   o_overrun_err               pulse when a byte arrives while executing/sending
module alu_uart_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_OPCODE      = 6,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic        [NB_DATA-1:0] i_rx_data,
    input  logic                      i_rx_valid,
    output logic signed [NB_DATA-1:0] o_op_1,
    output logic signed [NB_DATA-1:0] o_op_2,
    output logic      [NB_OPCODE-1:0] o_opcode,
    input  logic signed [NB_DATA-1:0] i_alu_result,
    output logic signed [NB_DATA-1:0] o_tx_data,
    output logic                      o_tx_start,
    input  logic                      i_tx_done,
    output logic                      o_busy,
    output logic                      o_timeout_err,
    output logic                      o_overrun_err
);

    localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);

    seq_state_t state, state_next;

    logic load_op1, load_op2, load_opcode, capture, overrun, timeout;
    logic cnt_en, cnt_clr, cnt_expired;

    // High bits of the opcode byte are deliberately discarded.
    logic unused_rx_hi;
    assign unused_rx_hi = ^i_rx_data;

    // The counter only runs while waiting mid-frame with no byte; any byte,
    // any other state, or the expiry itself restarts it from zero.
    assign cnt_en  = ((state == GET_OP2) || (state == GET_OPCODE)) && !i_rx_valid;
    assign cnt_clr = !cnt_en || cnt_expired;

    frame_timeout_counter #(
        .CYCLES (TIMEOUT_CYCLES),
        .CNT_W  (CNT_W)
    ) u_timeout (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (cnt_clr),
        .i_enable  (cnt_en),
        .o_expired (cnt_expired)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= GET_OP1;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load_op1    = 1'b0;
        load_op2    = 1'b0;
        load_opcode = 1'b0;
        capture     = 1'b0;
        overrun     = 1'b0;
        timeout     = 1'b0;
        case (state)
            GET_OP1: begin
                if (i_rx_valid) begin
                    load_op1   = 1'b1;
                    state_next = GET_OP2;
                end
            end
            GET_OP2: begin
                if (i_rx_valid) begin
                    load_op2   = 1'b1;
                    state_next = GET_OPCODE;
                end else if (cnt_expired) begin
                    timeout    = 1'b1;
                    state_next = GET_OP1;
                end
            end
            GET_OPCODE: begin
                if (i_rx_valid) begin
                    load_opcode = 1'b1;
                    state_next  = EXEC;
                end else if (cnt_expired) begin
                    timeout    = 1'b1;
                    state_next = GET_OP1;
                end
            end
            EXEC: begin
                // Single ALU settle cycle; result is sampled at its closing edge.
                capture    = 1'b1;
                overrun    = i_rx_valid;
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                overrun = i_rx_valid;
                // A done coinciding with our own start pulse cannot belong to
                // this transmission, so it is ignored.
                if (i_tx_done && !o_tx_start) begin
                    state_next = GET_OP1;
                end
            end
            default: state_next = GET_OP1;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_op_1        <= '0;
            o_op_2        <= '0;
            o_opcode      <= '0;
            o_tx_data     <= '0;
            o_tx_start    <= 1'b0;
            o_timeout_err <= 1'b0;
            o_overrun_err <= 1'b0;
        end else begin
            if (load_op1)    o_op_1    <= i_rx_data;
            if (load_op2)    o_op_2    <= i_rx_data;
            if (load_opcode) o_opcode  <= i_rx_data[NB_OPCODE-1:0];
            if (capture)     o_tx_data <= i_alu_result;
            o_tx_start    <= capture;
            o_timeout_err <= timeout;
            o_overrun_err <= overrun;
        end
    end

    assign o_busy = (state != GET_OP1);

endmodule

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
Sequences the combinational ALU from a byte stream delivered by the UART receiver. The stream is three bytes in order: operand 1, operand 2, opcode. After the third byte the block executes the operation, captures the ALU result and hands it to the UART transmitter with a start/done handshake. It sits between uart_rx/uart_tx and the alu instance, and replaces the pushbutton loader on the serial build.

Parameters:
NB_DATA, 8, width of operands, result and UART bytes
NB_OPCODE, 6, ALU opcode width; taken from the low bits of the opcode byte (NB_OPCODE <= NB_DATA)
TIMEOUT_CYCLES, 100_000_000, max idle clocks between bytes of one frame (1 s at 100 MHz)

Ports:
i_clock  in  1  system clock, rising edge
i_reset_n  in  1  reset, asynchronous, active-low
i_rx_data  in  NB_DATA  received byte, valid only when i_rx_valid=1
i_rx_valid  in  1  one-cycle strobe from uart_rx
o_op_1  out  NB_DATA  signed operand 1 to ALU
o_op_2  out  NB_DATA  signed operand 2 to ALU
o_opcode  out  NB_OPCODE  opcode to ALU
i_alu_result  in  NB_DATA  signed ALU result (combinational from o_op_*/o_opcode)
o_tx_data  out  NB_DATA  result byte to uart_tx, held stable until i_tx_done
o_tx_start  out  1  one-cycle start pulse to uart_tx
i_tx_done  in  1  one-cycle strobe from uart_tx, transmission finished
o_busy  out  1  high in any state other than GET_OP1
o_timeout_err  out  1  one-cycle pulse on frame timeout
o_overrun_err  out  1  one-cycle pulse when a byte is dropped

Behaviour:
- Reset (i_reset_n=0, asynchronous): state=GET_OP1; o_op_1, o_op_2, o_opcode, o_tx_data = 0; o_tx_start, o_timeout_err, o_overrun_err = 0; timeout counter = 0. o_busy=0 follows from state.
- All outputs are registered except o_busy, which is decoded from state.
- States: GET_OP1, GET_OP2, GET_OPCODE, EXEC, WAIT_TX.
- GET_OP1: on i_rx_valid, o_op_1<=i_rx_data, go to GET_OP2, clear counter.
- GET_OP2: on i_rx_valid, o_op_2<=i_rx_data, go to GET_OPCODE, clear counter.
- GET_OPCODE: on i_rx_valid, o_opcode<=i_rx_data[NB_OPCODE-1:0], go to EXEC.
- EXEC: lasts exactly 1 cycle, which is the ALU settle cycle. At its closing edge: o_tx_data<=i_alu_result, o_tx_start<=1, go to WAIT_TX.
- WAIT_TX: o_tx_start returns to 0 after one cycle. i_tx_done takes the state to GET_OP1. i_tx_done is ignored in the cycle o_tx_start=1.
- Latency: opcode byte sampled at edge k; o_tx_start=1 and o_tx_data valid during the cycle after edge k+1.
- Timeout, GET_OP2 and GET_OPCODE only:
  - The counter increments each cycle without i_rx_valid.
  - When it reaches TIMEOUT_CYCLES-1 with no byte, pulse o_timeout_err and go to GET_OP1.
  - Partially loaded operands keep their values.
  - If i_rx_valid coincides with expiry, the byte wins and no error is raised.
- Overrun: i_rx_valid in EXEC or WAIT_TX drops the byte and pulses o_overrun_err the next cycle. State is unaffected.
- o_op_1, o_op_2 and o_opcode hold their last values between frames so LED displays stay stable. A new frame overwrites them byte by byte.
- Reset asserted mid-frame or mid-transmit: immediate return to the reset state. The transmitter is not notified, and uart_tx shares the reset.
- Arithmetic is owned by the ALU. This block truncates only the opcode byte.

Decomposition:
- Package alu_seq_pkg holds:
  - state encoding constants (3-bit, 5 states);
  - TIMEOUT counter width, computed as $clog2(TIMEOUT_CYCLES);
  - frame length constant (3).
- Sub-module frame_timeout_counter (clear, enable, expired output). It is reused by later serial blocks.
- The ALU stays instantiated at top level, outside this block.

Test Plan:
1. Bytes 0x05, 0x03, 0x20 (ADD), with the ALU modelled → o_op_1=5, o_op_2=3, o_opcode=0x20. o_tx_start pulses 2 cycles after the opcode strobe with o_tx_data=0x08. i_tx_done then returns to GET_OP1 with o_busy=0.
2. Bytes 0xFE, 0x01, 0xE2 → o_opcode=0x22 (low 6 bits); SUB result 0xFD captured in o_tx_data and held until i_tx_done.
3. Byte 0x05, then silence of TIMEOUT_CYCLES (set to 16 in bench) → o_timeout_err pulses once at cycle 16 and state returns to GET_OP1. The next three bytes form a fresh frame.
4. Byte strobe during WAIT_TX → o_overrun_err pulses, o_op_1 unchanged, and the frame completes normally after i_tx_done.
5. Reset asserted asynchronously (mid-cycle) during GET_OPCODE → all outputs 0 immediately and state GET_OP1. The frame after release computes correctly.
6. i_tx_done asserted in the same cycle as o_tx_start → ignored and the block stays in WAIT_TX. A later i_tx_done releases it.
